test19_pixel_server: RTL and testbench

- RPC-style hardware server exposing three methods to one client: start, get_id and setget_pixel.
- Each method has its own four-phase req/ack handshake.
- The server holds an 8-bit-per-pixel frame buffer that the client reads and writes by (x,y) coordinate.
- Sits beside the client in the system top and is wired point-to-point to the client's Test19_Server1_* ports.

---
 rtl/test19_pixel_server_pkg.sv | 23 ++
 rtl/test19_pixel_server_if.sv | 30 +++
 rtl/test19_pixel_ram.sv | 24 ++
 rtl/test19_pixel_server.sv | 153 +++++++++++++++
 tb/tb_test19_pixel_server.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/test19_pixel_server_pkg.sv
// Shared constants and state encodings for the test19 pixel server.
// Defaults here feed the top-level parameters.
package test19_pkg;

   localparam logic [15:0] SERVER_ID_DEF = 16'h0013;
   localparam int          XDIM_DEF      = 32;
   localparam int          YDIM_DEF      = 32;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RD,
      ACKW
   } state_e;

   // Remembers which method owns the current call so ACKW watches the right req.
   typedef enum logic [1:0] {
      CALL_START,
      CALL_ID,
      CALL_PIX
   } call_e;

endpackage

// File: rtl/test19_pixel_server_if.sv
// Client/server call bus: one four-phase req/ack pair per method.
// Plus the arguments and return buses for each method.
interface test19_pixel_server_if;

   logic               start_req;
   logic               start_ack;
   logic               get_id_req;
   logic               get_id_ack;
   logic [15:0]        get_id_return;
   logic               setget_pixel_req;
   logic               setget_pixel_ack;
   logic [7:0]         setget_pixel_return;
   logic signed [31:0] setget_pixel_axx;
   logic signed [31:0] setget_pixel_ayy;
   logic               setget_pixel_readf;
   logic [7:0]         setget_pixel_wdata;

   modport master (
      output start_req, get_id_req, setget_pixel_req,
      output setget_pixel_axx, setget_pixel_ayy, setget_pixel_readf, setget_pixel_wdata,
      input  start_ack, get_id_ack, get_id_return, setget_pixel_ack, setget_pixel_return
   );

   modport slave (
      input  start_req, get_id_req, setget_pixel_req,
      input  setget_pixel_axx, setget_pixel_ayy, setget_pixel_readf, setget_pixel_wdata,
      output start_ack, get_id_ack, get_id_return, setget_pixel_ack, setget_pixel_return
   );

endinterface

// File: rtl/test19_pixel_ram.sv
// Single-port synchronous frame-buffer RAM, 8-bit pixels, registered read data.
// Read-during-write returns the old contents.
module test19_pixel_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // NOTE: the array has no reset so it maps onto a RAM macro; the server clears it explicitly.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/test19_pixel_server.sv
// RPC-style pixel server: start clears the frame, get_id returns a constant,
// setget_pixel reads or writes one pixel by signed (x,y) coordinate.
module test19_pixel_server
   import test19_pkg::*;
#(
   parameter logic [15:0] SERVER_ID = SERVER_ID_DEF,
   parameter int          XDIM      = XDIM_DEF,
   parameter int          YDIM      = YDIM_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   test19_pixel_server_if.slave  bus
);

   localparam int            DEPTH = XDIM * YDIM;
   localparam int            AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   state_e        state_q;
   call_e         call_q;
   logic [AW-1:0] clr_cnt_q;
   logic          start_ack_q;
   logic          get_id_ack_q;
   logic          pix_ack_q;
   logic [15:0]   get_id_ret_q;
   logic [7:0]    pix_ret_q;
   logic          readf_q;
   logic          in_range_q;
   logic [7:0]    wdata_q;

   logic          pix_go;
   logic          in_range;
   logic [AW-1:0] pix_addr;
   logic          active_req;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   // Signed compare first; only an in-range coordinate may be truncated into an address.
   assign in_range = ($signed(bus.setget_pixel_axx) >= 0) && ($signed(bus.setget_pixel_axx) < XDIM) &&
                     ($signed(bus.setget_pixel_ayy) >= 0) && ($signed(bus.setget_pixel_ayy) < YDIM);
   assign pix_addr = AW'(bus.setget_pixel_ayy * XDIM + bus.setget_pixel_axx);
   assign pix_go   = bus.setget_pixel_req && !bus.start_req && !bus.get_id_req;

   // NOTE: every always_comb output gets a default up front so no path can infer a latch.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = pix_addr;
      ram_wdata = bus.setget_pixel_wdata;
      if (state_q == CLEAR) begin
         ram_we    = 1'b1;
         ram_addr  = clr_cnt_q;
         ram_wdata = 8'h00;
      end else if (state_q == IDLE && pix_go && !bus.setget_pixel_readf && in_range) begin
         ram_we = 1'b1;
      end
   end

   always_comb begin
      active_req = 1'b0;
      case (call_q)
         CALL_START: active_req = bus.start_req;
         CALL_ID:    active_req = bus.get_id_req;
         CALL_PIX:   active_req = bus.setget_pixel_req;
         default:    active_req = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         call_q       <= CALL_START;
         clr_cnt_q    <= '0;
         start_ack_q  <= 1'b0;
         get_id_ack_q <= 1'b0;
         pix_ack_q    <= 1'b0;
         get_id_ret_q <= '0;
         pix_ret_q    <= '0;
         readf_q      <= 1'b0;
         in_range_q   <= 1'b0;
         wdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_req) begin
                  state_q   <= CLEAR;
                  call_q    <= CALL_START;
                  clr_cnt_q <= '0;
               end else if (bus.get_id_req) begin
                  state_q      <= ACKW;
                  call_q       <= CALL_ID;
                  get_id_ack_q <= 1'b1;
                  get_id_ret_q <= SERVER_ID;
               end else if (bus.setget_pixel_req) begin
                  state_q    <= RD;
                  call_q     <= CALL_PIX;
                  readf_q    <= bus.setget_pixel_readf;
                  in_range_q <= in_range;
                  wdata_q    <= bus.setget_pixel_wdata;
               end
            end
            CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST) begin
                  state_q     <= ACKW;
                  start_ack_q <= 1'b1;
               end
            end
            RD: begin
               // RAM read data lands this cycle; writes echo their data.
               if (!in_range_q) begin
                  pix_ret_q <= 8'h00;
               end else if (readf_q) begin
                  pix_ret_q <= ram_rdata;
               end else begin
                  pix_ret_q <= wdata_q;
               end
               pix_ack_q <= 1'b1;
               state_q   <= ACKW;
            end
            ACKW: begin
               if (!active_req) begin
                  start_ack_q  <= 1'b0;
                  get_id_ack_q <= 1'b0;
                  pix_ack_q    <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   test19_pixel_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign bus.start_ack           = start_ack_q;
   assign bus.get_id_ack          = get_id_ack_q;
   assign bus.get_id_return       = get_id_ret_q;
   assign bus.setget_pixel_ack    = pix_ack_q;
   assign bus.setget_pixel_return = pix_ret_q;

endmodule

// File: tb/tb_test19_pixel_server.sv
// Directed bench for test19_pixel_server: handshakes, latencies, clear,
// in/out-of-range pixel access, arbitration and reset during clear.
module tb_test19_pixel_server;
   import test19_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   lat;
   bit   seen;

   test19_pixel_server_if bus ();

   test19_pixel_server dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_ack(input int sel);
      case (sel)
         0:       return bus.start_ack;
         1:       return bus.get_id_ack;
         default: return bus.setget_pixel_ack;
      endcase
   endfunction

   // Counts cycles from the current point until the selected ack is seen high.
   task automatic wait_ack(input int sel, input int max, output int n);
      n = 0;
      while (n < max) begin
         @(posedge clk);
         #1;
         n++;
         if (get_ack(sel)) break;
      end
   endtask

   task automatic pix_call(input string tag, input int x, input int y, input bit rd,
                           input logic [7:0] wd, input logic [7:0] exp);
      int n;
      bus.setget_pixel_axx   = x;
      bus.setget_pixel_ayy   = y;
      bus.setget_pixel_readf = rd;
      bus.setget_pixel_wdata = wd;
      bus.setget_pixel_req   = 1'b1;
      wait_ack(2, 20, n);
      check({tag, "_lat"}, n, 2);
      check({tag, "_ret"}, {24'h0, bus.setget_pixel_return}, {24'h0, exp});
      bus.setget_pixel_req = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_ackdrop"}, {31'h0, bus.setget_pixel_ack}, 0);
   endtask

   task automatic start_call(input string tag);
      int n;
      bus.start_req = 1'b1;
      wait_ack(0, 1100, n);
      check({tag, "_lat"}, n, 1025);
      bus.start_req = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_ackdrop"}, {31'h0, bus.start_ack}, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.start_req          = 1'b0;
      bus.get_id_req         = 1'b0;
      bus.setget_pixel_req   = 1'b0;
      bus.setget_pixel_axx   = '0;
      bus.setget_pixel_ayy   = '0;
      bus.setget_pixel_readf = 1'b0;
      bus.setget_pixel_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_start_ack", {31'h0, bus.start_ack}, 0);
      check("rst_get_id_ack", {31'h0, bus.get_id_ack}, 0);
      check("rst_pix_ack", {31'h0, bus.setget_pixel_ack}, 0);
      check("rst_get_id_ret", {16'h0, bus.get_id_return}, 0);
      check("rst_pix_ret", {24'h0, bus.setget_pixel_return}, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // get_id handshake
      bus.get_id_req = 1'b1;
      wait_ack(1, 20, lat);
      check("id_lat", lat, 1);
      check("id_ret", {16'h0, bus.get_id_return}, 32'h0013);
      @(posedge clk);
      #1;
      check("id_ack_hold", {31'h0, bus.get_id_ack}, 1);
      bus.get_id_req = 1'b0;
      @(posedge clk);
      #1;
      check("id_ackdrop", {31'h0, bus.get_id_ack}, 0);
      check("id_ret_keep", {16'h0, bus.get_id_return}, 32'h0013);

      start_call("start1");
      pix_call("rd_5_7_clr", 5, 7, 1'b1, 8'h00, 8'h00);
      pix_call("wr_5_7", 5, 7, 1'b0, 8'hA5, 8'hA5);
      pix_call("rd_5_7", 5, 7, 1'b1, 8'h00, 8'hA5);
      pix_call("rd_7_5", 7, 5, 1'b1, 8'h00, 8'h00);
      pix_call("wr_31_31", 31, 31, 1'b0, 8'h3C, 8'h3C);
      pix_call("rd_31_31", 31, 31, 1'b1, 8'h00, 8'h3C);
      pix_call("wr_m1_0", -1, 0, 1'b0, 8'hFF, 8'h00);
      pix_call("wr_32_0", 32, 0, 1'b0, 8'hFF, 8'h00);
      pix_call("rd_0_0", 0, 0, 1'b1, 8'h00, 8'h00);
      pix_call("rd_31_0", 31, 0, 1'b1, 8'h00, 8'h00);
      pix_call("rd_0_32", 0, 32, 1'b1, 8'h00, 8'h00);

      // Request withdrawn before ack: ack still pulses for one cycle
      bus.setget_pixel_axx   = 31;
      bus.setget_pixel_ayy   = 31;
      bus.setget_pixel_readf = 1'b1;
      bus.setget_pixel_req   = 1'b1;
      @(posedge clk);
      #1;
      bus.setget_pixel_req = 1'b0;
      check("wd_ack_early", {31'h0, bus.setget_pixel_ack}, 0);
      @(posedge clk);
      #1;
      check("wd_ack", {31'h0, bus.setget_pixel_ack}, 1);
      check("wd_ret", {24'h0, bus.setget_pixel_return}, 32'h3C);
      @(posedge clk);
      #1;
      check("wd_ackdrop", {31'h0, bus.setget_pixel_ack}, 0);

      // Simultaneous get_id and pixel read: get_id wins, pixel waits
      bus.setget_pixel_axx   = 5;
      bus.setget_pixel_ayy   = 7;
      bus.setget_pixel_readf = 1'b1;
      bus.get_id_req         = 1'b1;
      bus.setget_pixel_req   = 1'b1;
      wait_ack(1, 20, lat);
      check("arb_id_lat", lat, 1);
      check("arb_pix_idle", {31'h0, bus.setget_pixel_ack}, 0);
      bus.get_id_req = 1'b0;
      @(posedge clk);
      #1;
      check("arb_id_drop", {31'h0, bus.get_id_ack}, 0);
      wait_ack(2, 20, lat);
      check("arb_pix_lat", lat, 2);
      check("arb_pix_ret", {24'h0, bus.setget_pixel_return}, 32'hA5);
      bus.setget_pixel_req = 1'b0;
      @(posedge clk);
      #1;
      check("arb_pix_drop", {31'h0, bus.setget_pixel_ack}, 0);

      // Reset 100 cycles into a clear
      bus.start_req = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.start_req = 1'b0;
      #1;
      check("mid_rst_start_ack", {31'h0, bus.start_ack}, 0);
      check("mid_rst_pix_ret", {24'h0, bus.setget_pixel_return}, 0);
      check("mid_rst_id_ret", {16'h0, bus.get_id_return}, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      seen  = 1'b0;
      repeat (1100) begin
         @(posedge clk);
         #1;
         if (bus.start_ack) seen = 1'b1;
      end
      check("mid_rst_no_ack", {31'h0, seen}, 0);
      check("mid_rst_idle", {30'h0, dut.state_q}, {30'h0, IDLE});

      start_call("start2");
      pix_call("rd_0_0_after", 0, 0, 1'b1, 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
